// File: rtl/au_sub_serial.sv
// au_sub_serial: digit-serial subtractor, d = a - b - bi over WIDTH bits,
// DIGIT bits per clock with a rippled borrow register between digits.
// Optional build macro AU_SUB_SERIAL_SAT_EN: unsigned saturation, the
// result is forced to zero when the final borrow is set (bo stays true).
module au_sub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  // Operands are padded to a whole number of digits so the last digit
  // reads zero-extended bits.
  localparam int PW   = NDIG * DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});
  localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   diff;

  // Current digit slice and its DIGIT+1 bit difference; MSB is the borrow.
  always_comb begin
    base  = 32'(cnt_q) * 32'(DIGIT);
    a_dig = DIGIT'(a_q >> base);
    b_dig = DIGIT'(b_q >> base);
    diff  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, br_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = PW'(a);
          b_d     = PW'(b);
          br_d    = bi;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shifting in a WIDTH-wide word drops the padding bits of a
        // partial final digit.
        res_d = (res_q & ~(DMASK << base)) | (WIDTH'(diff[DIGIT-1:0]) << base);
        br_d  = diff[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bo_d    = diff[DIGIT];
          state_d = DONE;
`ifdef AU_SUB_SERIAL_SAT_EN
          if (diff[DIGIT]) res_d = '0;
`else
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = res_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_au_sub_serial.sv
module tb_au_sub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 8-bit-digit instance
  logic        iv32 = 0, ir32, ov32, or32 = 0, bi32 = 0, bo32;
  logic [31:0] a32 = '0, b32 = '0, d32;
  // 10-bit / 4-bit-digit instance (partial final digit)
  logic        iv10 = 0, ir10, ov10, or10 = 0, bi10 = 0, bo10;
  logic [9:0]  a10 = '0, b10 = '0, d10;

  au_sub_serial #(.WIDTH(32), .DIGIT(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .bi(bi32), .out_valid(ov32), .out_ready(or32), .d(d32), .bo(bo32));

  au_sub_serial #(.WIDTH(10), .DIGIT(4)) u10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .a(a10), .b(b10),
    .bi(bi10), .out_valid(ov10), .out_ready(or10), .d(d10), .bo(bo10));

  typedef struct {
    logic [31:0] a, b;
    logic        bi;
    logic [31:0] ed;
    logic        eb;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        bo;
  } res_t;

  res_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_d(input logic [31:0] ed, input logic eb);
`ifdef AU_SUB_SERIAL_SAT_EN
    return eb ? 32'h0 : ed;
`else
    return ed;
`endif
  endfunction

  task automatic pop_exp(output res_t e);
    if (sb.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e.d = 'x; e.bo = 1'bx;
    end else e = sb.pop_front();
  endtask

  // One full 32-bit operation; called on a negedge with the DUT idle.
  task automatic op32(input vec_t v);
    int   n;
    res_t e;
    chk("in_ready_idle32", ir32, 1);
    a32 = v.a; b32 = v.b; bi32 = v.bi; iv32 = 1;
    @(posedge clk);
    sb.push_back('{sat_d(v.ed, v.eb), v.eb});
    @(negedge clk);
    iv32 = 0; a32 = $urandom; b32 = $urandom; bi32 = 1'b1;
    n = 0;
    while (!ov32 && n < 20) begin
      chk("in_ready_run32", ir32, 0);
      @(negedge clk);
      n++;
    end
    chk("latency32", n, 4);
    chk("in_ready_done32", ir32, 0);
    pop_exp(e);
    for (int h = 0; h < v.hold; h++) begin
      iv32 = 1; a32 = 32'hDEAD_BEEF; b32 = 32'h1;
      chk("hold_valid32", ov32, 1);
      chk("hold_d32", d32, e.d);
      chk("hold_bo32", bo32, e.bo);
      chk("hold_in_ready32", ir32, 0);
      @(negedge clk);
    end
    iv32 = 0;
    chk("d32", d32, e.d);
    chk("bo32", bo32, e.bo);
    or32 = 1;
    @(negedge clk);
    or32 = 0;
    chk("valid_drop32", ov32, 0);
    chk("in_ready_back32", ir32, 1);
  endtask

  task automatic op10(input logic [9:0] a, input logic [9:0] b, input logic [9:0] ed, input logic eb);
    int   n;
    res_t e;
    chk("in_ready_idle10", ir10, 1);
    a10 = a; b10 = b; bi10 = 0; iv10 = 1;
    @(posedge clk);
    sb.push_back('{sat_d({22'h0, ed}, eb), eb});
    @(negedge clk);
    iv10 = 0; a10 = '1; b10 = '0;
    n = 0;
    while (!ov10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency10", n, 3);
    pop_exp(e);
    chk("d10", d10, e.d[9:0]);
    chk("bo10", bo10, e.bo);
    or10 = 1;
    @(negedge clk);
    or10 = 0;
    chk("in_ready_back10", ir10, 1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'h1234_5678, 32'h0234_5677, 1'b0, 32'h1000_0001, 1'b0, 0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 0};
    tbl[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 0};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 0};
    tbl[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 0};
    tbl[5] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 5};

    // Reset state
    #1;
    chk("rst_in_ready", ir32, 1);
    chk("rst_out_valid", ov32, 0);
    chk("rst_d", d32, 0);
    chk("rst_bo", bo32, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    foreach (tbl[i]) op32(tbl[i]);

    op10(10'h3FF, 10'h001, 10'h3FE, 1'b0);
    op10(10'h000, 10'h3FF, 10'h001, 1'b1);

    // Abort mid-RUN: reset pulsed in cycle 2 of RUN
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; bi32 = 0; iv32 = 1;
    @(posedge clk);
    sb.push_back('{32'hFFFF_FFFF, 1'b0});
    @(negedge clk);
    iv32 = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    sb.delete();
    chk("abort_in_ready", ir32, 1);
    chk("abort_out_valid", ov32, 0);
    chk("abort_d", d32, 0);
    chk("abort_bo", bo32, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op32('{32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 0});

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
